// File: rtl/lkup_igr_sched_pkg.sv
// Shared types for the lookup-stage ingress scheduler: segment sideband and FSM states.
package lkup_igr_sched_pkg;

    localparam int unsigned DROP_CNT_W = 32;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [6:0] bytesvld;
    } segment_info_t;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDrop
    } sch_state_e;

endpackage

// File: rtl/lkup_igr_sched_if.sv
// Bundles the ingress FIFO heads and the scheduler-to-lookup stream.
// slave = scheduler side, master = FIFO/lookup environment side.
interface lkup_igr_sched_if
    import lkup_igr_sched_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH        = 512,
    parameter int unsigned USERMETADATA_WIDTH = 1,
    parameter int unsigned NUM_IGR_FIFOS      = 12,
    parameter int unsigned IGR_FIFO_DEPTH     = 512
) ();

    localparam int unsigned OCC_W = $clog2(IGR_FIFO_DEPTH);

    logic          [NUM_IGR_FIFOS-1:0]                         igr_fifo_empty;
    logic          [NUM_IGR_FIFOS-1:0]                         igr_fifo_rd;
    logic          [NUM_IGR_FIFOS-1:0][TDATA_WIDTH-1:0]        igr_tdata;
    logic          [NUM_IGR_FIFOS-1:0][USERMETADATA_WIDTH-1:0] igr_tuser_usermetadata;
    segment_info_t [NUM_IGR_FIFOS-1:0]                         igr_tuser_segment_info;
    logic          [NUM_IGR_FIFOS-1:0][OCC_W-1:0]              igr_fifo_occ;

    logic                          sch2lu_tready;
    logic                          sch2lu_tvalid;
    logic [TDATA_WIDTH-1:0]        sch2lu_tdata;
    logic [USERMETADATA_WIDTH-1:0] sch2lu_tuser_usermetadata;
    segment_info_t                 sch2lu_tuser_segment_info;

    modport slave (
        input  igr_fifo_empty,
        input  igr_tdata,
        input  igr_tuser_usermetadata,
        input  igr_tuser_segment_info,
        input  igr_fifo_occ,
        input  sch2lu_tready,
        output igr_fifo_rd,
        output sch2lu_tvalid,
        output sch2lu_tdata,
        output sch2lu_tuser_usermetadata,
        output sch2lu_tuser_segment_info
    );

    modport master (
        output igr_fifo_empty,
        output igr_tdata,
        output igr_tuser_usermetadata,
        output igr_tuser_segment_info,
        output igr_fifo_occ,
        output sch2lu_tready,
        input  igr_fifo_rd,
        input  sch2lu_tvalid,
        input  sch2lu_tdata,
        input  sch2lu_tuser_usermetadata,
        input  sch2lu_tuser_segment_info
    );

endinterface

// File: rtl/lkup_igr_sched_rr_pick.sv
// Rotate-priority first-one finder: first set bit of req_i at or above ptr_i, modulo N.
module lkup_igr_sched_rr_pick #(
    parameter int unsigned N     = 12,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found_o && req_i[cand_idx]) begin
                found_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/lkup_igr_sched.sv
// Packet-granular weighted round-robin scheduler with per-FIFO occupancy drop in front of lookup.
// Define PKT_SW_SCH_DROP_CNT_EN to add per-FIFO saturating dropped-packet counters.
module lkup_igr_sched
    import lkup_igr_sched_pkg::*;
#(
    parameter  int unsigned TDATA_WIDTH        = 512,
    parameter  int unsigned USERMETADATA_WIDTH = 1,
    parameter  int unsigned NUM_IGR_FIFOS      = 12,
    parameter  int unsigned IGR_FIFO_DEPTH     = 512,
    parameter  int unsigned WEIGHT_W           = 4,
    localparam int unsigned OCC_W              = $clog2(IGR_FIFO_DEPTH)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    lkup_igr_sched_if.slave                         bus_io,
    input  logic [NUM_IGR_FIFOS-1:0][OCC_W-1:0]     cfg_drop_threshd_i,
    input  logic [NUM_IGR_FIFOS-1:0][WEIGHT_W-1:0]  cfg_weight_i,
`ifdef PKT_SW_SCH_DROP_CNT_EN
    output logic [NUM_IGR_FIFOS-1:0][DROP_CNT_W-1:0] sch_drop_cnt_o,
`endif
    output logic                                    sch_sop_err_o
);

    localparam int unsigned IDX_W = (NUM_IGR_FIFOS > 1) ? $clog2(NUM_IGR_FIFOS) : 1;

    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    sch_state_e                              state_q, state_d;
    logic [IDX_W-1:0]                        g_q, g_d;
    logic [IDX_W-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [NUM_IGR_FIFOS-1:0][WEIGHT_W-1:0]  credit_q, credit_d;
    logic [WEIGHT_W-1:0]                     weight_q, weight_d;
    logic                                    cred_init_q, cred_init_d;
    logic                                    sop_err_q, sop_err_d;

    logic [NUM_IGR_FIFOS-1:0] req;
    logic                     pick_found;
    logic [IDX_W-1:0]         pick_idx;
    segment_info_t            pick_si;
    logic                     over_thr;
    segment_info_t            head_si;
    logic                     head_empty;
    logic                     pop;
    logic                     pkt_end;
    logic                     tvalid;
    logic [IDX_W-1:0]         g_next;
    logic [NUM_IGR_FIFOS-1:0] rd;

    assign req = ~bus_io.igr_fifo_empty;

    lkup_igr_sched_rr_pick #(
        .N     (NUM_IGR_FIFOS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign pick_si    = bus_io.igr_tuser_segment_info[pick_idx];
    assign over_thr   = (cfg_drop_threshd_i[pick_idx] != '0) &&
                        (bus_io.igr_fifo_occ[pick_idx] >= cfg_drop_threshd_i[pick_idx]);
    assign head_si    = bus_io.igr_tuser_segment_info[g_q];
    assign head_empty = bus_io.igr_fifo_empty[g_q];
    assign g_next     = (g_q == IDX_W'(NUM_IGR_FIFOS - 1)) ? '0 : g_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_ptr_d    = rr_ptr_q;
        credit_d    = credit_q;
        weight_d    = weight_q;
        cred_init_d = cred_init_q;
        sop_err_d   = sop_err_q;
        pop         = 1'b0;
        tvalid      = 1'b0;
        pkt_end     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!cred_init_q) begin
                    for (int unsigned i = 0; i < NUM_IGR_FIFOS; i++) begin
                        credit_d[i] = eff_weight(cfg_weight_i[i]);
                    end
                    cred_init_d = 1'b1;
                end else if (bus_io.igr_fifo_empty[rr_ptr_q]) begin
                    // Turn holder ran dry: it forfeits the rest of its turn.
                    credit_d[rr_ptr_q] = eff_weight(cfg_weight_i[rr_ptr_q]);
                end
                if (pick_found) begin
                    g_d      = pick_idx;
                    weight_d = eff_weight(cfg_weight_i[pick_idx]);
                    if (!pick_si.sop) begin
                        sop_err_d = 1'b1;
                        state_d   = StDrop;
                    end else if (over_thr) begin
                        state_d = StDrop;
                    end else begin
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                tvalid = !head_empty;
                pop    = tvalid & bus_io.sch2lu_tready;
            end
            StDrop: begin
                pop = !head_empty;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rst) begin
            tvalid = 1'b0;
            pop    = 1'b0;
        end

        pkt_end = pop & head_si.eop;
        if (pkt_end) begin
            state_d = StIdle;
            if (credit_q[g_q] <= WEIGHT_W'(1)) begin
                credit_d[g_q] = weight_q;
                rr_ptr_d      = g_next;
            end else begin
                credit_d[g_q] = credit_q[g_q] - WEIGHT_W'(1);
                rr_ptr_d      = g_q;
            end
        end
    end

    always_comb begin
        rd      = '0;
        rd[g_q] = pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            credit_q    <= '0;
            weight_q    <= WEIGHT_W'(1);
            cred_init_q <= 1'b0;
            sop_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            credit_q    <= credit_d;
            weight_q    <= weight_d;
            cred_init_q <= cred_init_d;
            sop_err_q   <= sop_err_d;
        end
    end

    // Zero-latency datapath: the granted FIFO head is forwarded only while transferring.
    assign bus_io.igr_fifo_rd               = rd;
    assign bus_io.sch2lu_tvalid             = tvalid;
    assign bus_io.sch2lu_tdata              = (state_q == StXfer) ? bus_io.igr_tdata[g_q] : '0;
    assign bus_io.sch2lu_tuser_usermetadata =
        (state_q == StXfer) ? bus_io.igr_tuser_usermetadata[g_q] : '0;
    assign bus_io.sch2lu_tuser_segment_info = (state_q == StXfer) ? head_si : '0;
    assign sch_sop_err_o                    = sop_err_q;

`ifdef PKT_SW_SCH_DROP_CNT_EN
    logic [NUM_IGR_FIFOS-1:0][DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                                     drop_end;

    assign drop_end = pkt_end && (state_q == StDrop);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_end && (drop_cnt_q[g_q] != '1)) begin
            drop_cnt_d[g_q] = drop_cnt_q[g_q] + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sch_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: doc/lkup_igr_sched.md
Name: lkup_igr_sched

Overview:
- Packet-granular weighted round-robin scheduler in front of the lookup stage. It arbitrates NUM_IGR_FIFOS show-ahead ingress FIFOs onto the single lookup input stream, which feeds the TCAM request path and the latency FIFO.
- At each SOP it applies a per-FIFO occupancy drop threshold; a packet selected for drop is dequeued and discarded whole.
- The pipeline owns one instance.

Parameters:
- TDATA_WIDTH, 512, segment data width.
- USERMETADATA_WIDTH, 1, user metadata width.
- NUM_IGR_FIFOS, 12, number of ingress FIFOs arbitrated.
- IGR_FIFO_DEPTH, 512, ingress FIFO depth; OCC_W = $clog2(IGR_FIFO_DEPTH).
- WEIGHT_W, 4, width of the per-FIFO weight (packets per turn).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- igr_fifo_empty  in  NUM_IGR_FIFOS  per-FIFO empty.
- igr_fifo_rd  out  NUM_IGR_FIFOS  per-FIFO read (show-ahead pop).
- igr_tdata  in  NUM_IGR_FIFOS x TDATA_WIDTH  FIFO head data.
- igr_tuser_usermetadata  in  NUM_IGR_FIFOS x USERMETADATA_WIDTH  head metadata.
- igr_tuser_segment_info  in  NUM_IGR_FIFOS x SEGMENT_INFO_S  head segment info (sop/eop/bytesvld...).
- igr_fifo_occ  in  NUM_IGR_FIFOS x OCC_W  per-FIFO occupancy.
- cfg_drop_threshd  in  NUM_IGR_FIFOS x OCC_W  drop threshold; 0 = never drop.
- cfg_weight  in  NUM_IGR_FIFOS x WEIGHT_W  packets per round-robin turn; 0 treated as 1.
- sch2lu_tready  in  1  downstream ready.
- sch2lu_tvalid  out  1  segment valid.
- sch2lu_tdata  out  TDATA_WIDTH  segment data.
- sch2lu_tuser_usermetadata  out  USERMETADATA_WIDTH  metadata.
- sch2lu_tuser_segment_info  out  SEGMENT_INFO_S  segment info.
- sch_sop_err  out  1  sticky; set when a granted head is not SOP.

Behaviour:
- State machine has three states: IDLE, XFER, DROP. Registers: grant index g, round-robin pointer rr_ptr, per-FIFO credit counter.

IDLE:
- Pick the first non-empty FIFO searching from rr_ptr upward, modulo NUM_IGR_FIFOS. Register it as g.
- If its head is not SOP: set sch_sop_err and go to DROP (resync by discarding).
- Else if cfg_drop_threshd[g] != 0 and igr_fifo_occ[g] >= cfg_drop_threshd[g]: go to DROP.
- Else go to XFER.
- No candidate: stay in IDLE.
- All outputs are 0 in IDLE.

XFER:
- sch2lu_tvalid = !igr_fifo_empty[g].
- Data, metadata and segment info are combinational from FIFO g head (0-cycle datapath latency).
- igr_fifo_rd[g] = sch2lu_tvalid & sch2lu_tready.
- FIFO empty mid-packet: tvalid low, stay in XFER.
- On a pop with eop: go to IDLE.

DROP:
- igr_fifo_rd[g] = !igr_fifo_empty[g], independent of tready.
- sch2lu_tvalid = 0.
- On a pop with eop: go to IDLE.

Single-segment packets:
- sop&eop takes one cycle in XFER or DROP.
- Arbitration costs one bubble cycle per packet (IDLE).

Credits and pointer, updated at packet end in both XFER and DROP:
- credit[g] decrements on each packet end.
- When it reaches 0, or when FIFO g is empty in IDLE: credit[g] is reloaded from max(cfg_weight[g],1) and rr_ptr = g+1, with wrap from NUM_IGR_FIFOS-1 to 0.
- Otherwise rr_ptr stays at g, so g keeps its turn.

Configuration timing:
- cfg_* is sampled only in IDLE/SOP; changes mid-packet have no effect until the next SOP.

Reset:
- All outputs 0, state IDLE, rr_ptr 0, credits loaded from weights in the first post-reset IDLE cycle, sch_sop_err 0.
- Reset mid-packet abandons the packet. Its remaining segments surface at a later grant as non-SOP and are discarded, setting sch_sop_err.

Invariants:
- At most one igr_fifo_rd bit is high per cycle.
- igr_fifo_rd is never asserted on an empty FIFO.

Optional Feature:
- Macro: PKT_SW_SCH_DROP_CNT_EN.
- With the macro: adds output sch_drop_cnt, NUM_IGR_FIFOS x 32.
  - It is a per-FIFO saturating counter of dropped packets (threshold or SOP-error drops), incremented on DROP eop.
  - Reset value is 0; it holds at 32'hFFFF_FFFF.
- Without the macro: the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- packet_switch_pkg: SEGMENT_INFO_S (existing); SCH_STATE_E enum {IDLE, XFER, DROP}.
- Sub-module lkup_sched_rr_pick: combinational rotate-priority first-one finder. Inputs are the request vector and rr_ptr; outputs are a found flag and the index.

Test Plan:
- FIFOs 0,1,2 each hold 2 single-segment packets, weights 1, tready=1 -> output order 0,1,2,0,1,2; one IDLE bubble between packets.
- cfg_weight[1]=3, FIFOs 0 and 1 each hold 4 packets -> order 0,1,1,1,0,1,0,0.
- FIFO 3 occ=480, cfg_drop_threshd[3]=480, one 4-segment packet -> 4 pops with tvalid=0 throughout; next packet from FIFO 3 at occ 479 passes.
- tready toggles 1010 during a 5-segment packet -> no segment lost or duplicated; igr_fifo_rd only on tvalid&tready cycles.
- Head of granted FIFO is a non-SOP segment -> sch_sop_err=1 and segments discarded up to eop; the next SOP packet is forwarded.
- rst asserted mid-packet in XFER -> next cycle all outputs 0, state IDLE, rr_ptr=0; with PKT_SW_SCH_DROP_CNT_EN, sch_drop_cnt reads 0.
